// File: rtl/flash_pkg.sv
// Shared definitions for the flash op sequencer: op codes, command bytes,
// error codes, SR1 bit positions and the per-op step list helpers.
package flash_pkg;

  localparam int unsigned OP_W   = 3;
  localparam int unsigned ADDR_W = 24;
  localparam int unsigned DATA_W = 48;
  localparam int unsigned CMD_W  = 8;
  localparam int unsigned ERR_W  = 2;
  localparam int unsigned STEP_W = 2;

  localparam logic [OP_W-1:0] OP_RDID = 3'd0;
  localparam logic [OP_W-1:0] OP_RSR1 = 3'd1;
  localparam logic [OP_W-1:0] OP_RES  = 3'd2;
  localparam logic [OP_W-1:0] OP_SE   = 3'd3;
  localparam logic [OP_W-1:0] OP_BE   = 3'd4;

  localparam logic [CMD_W-1:0] CMD_RDID = 8'h9F;
  localparam logic [CMD_W-1:0] CMD_RSR1 = 8'h05;
  localparam logic [CMD_W-1:0] CMD_RES  = 8'hAB;
  localparam logic [CMD_W-1:0] CMD_WREN = 8'h06;
  localparam logic [CMD_W-1:0] CMD_SE   = 8'hD8;
  localparam logic [CMD_W-1:0] CMD_BE   = 8'hC7;

  localparam logic [ERR_W-1:0] ERR_OK      = 2'd0;
  localparam logic [ERR_W-1:0] ERR_BADOP   = 2'd1;
  localparam logic [ERR_W-1:0] ERR_WEL     = 2'd2;
  localparam logic [ERR_W-1:0] ERR_TIMEOUT = 2'd3;

  localparam int unsigned SR1_WIP = 0;
  localparam int unsigned SR1_WEL = 1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_DECODE, ST_ISSUE, ST_WAIT_ACK, ST_WAIT_DONE, ST_EVAL, ST_RESP
  } state_e;

  typedef enum logic [1:0] { CHK_NONE, CHK_WEL, CHK_WIP } chk_e;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] addr;
  } req_t;

  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return (op <= OP_BE);
  endfunction

  function automatic logic op_is_write(input logic [OP_W-1:0] op);
    return (op == OP_SE) || (op == OP_BE);
  endfunction

  // Write-type ops expand to WREN, WEL check, erase, WIP check.
  function automatic logic [CMD_W-1:0] step_cmd(input logic [OP_W-1:0] op,
                                                input logic [STEP_W-1:0] step);
    logic [CMD_W-1:0] c;
    c = CMD_RSR1;
    case (op)
      OP_RDID: c = CMD_RDID;
      OP_RES:  c = CMD_RES;
      OP_SE, OP_BE: begin
        if (step == 2'd0)      c = CMD_WREN;
        else if (step == 2'd2) c = (op == OP_SE) ? CMD_SE : CMD_BE;
        else                   c = CMD_RSR1;
      end
      default: c = CMD_RSR1;
    endcase
    return c;
  endfunction

  function automatic chk_e step_chk(input logic [OP_W-1:0] op,
                                    input logic [STEP_W-1:0] step);
    chk_e k;
    k = CHK_NONE;
    if (op_is_write(op)) begin
      if (step == 2'd1)      k = CHK_WEL;
      else if (step == 2'd3) k = CHK_WIP;
    end
    return k;
  endfunction

  function automatic logic step_last(input logic [OP_W-1:0] op,
                                     input logic [STEP_W-1:0] step);
    return op_is_write(op) ? (step == 2'd3) : 1'b1;
  endfunction

endpackage

// File: rtl/flash_op_sequencer_rr_arbiter2.sv
// Two-way round-robin arbiter; a tie goes to the requester not granted last.
module rr_arbiter2 (
  input  logic       CLK,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  output logic       grant_valid_c,
  output logic       grant_idx_c
);

  logic last_grant;

  always_comb begin
    grant_valid_c = en & (|req);
    grant_idx_c   = 1'b0;
    if (req == 2'b11) grant_idx_c = ~last_grant;
    else              grant_idx_c = req[1];
  end

  always_ff @(posedge CLK) begin
    if (reset)              last_grant <= 1'b1;
    else if (grant_valid_c) last_grant <= grant_idx_c;
  end

endmodule

// File: rtl/flash_op_sequencer.sv
// Arbitrates two requesters and expands their high-level flash ops into the
// memory_controller command/trigger handshake, one response per request.
module flash_op_sequencer
  import flash_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter bit          QUAD        = 1'b0
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [ADDR_W-1:0] req0_addr,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_data,
  output logic [ERR_W-1:0]  rsp0_err,
  input  logic              req1_valid,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_data,
  output logic [ERR_W-1:0]  rsp1_err,
  output logic [CMD_W-1:0]  mem_cmd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [23:0]       mem_val,
  output logic              mem_trig,
  output logic              mem_quad,
  input  logic              mem_busy,
  input  logic [DATA_W-1:0] mem_data
);

  localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);

  state_e            state, state_d;
  req_t              req_q, req_d;
  logic              gnt_q, gnt_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [CNT_W-1:0]  ack_cnt_q, ack_cnt_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [DATA_W-1:0] cap_q, cap_d;

  logic              req0_ready_d, req1_ready_d, rsp0_valid_d, rsp1_valid_d;
  logic [DATA_W-1:0] rsp0_data_d, rsp1_data_d;
  logic [ERR_W-1:0]  rsp0_err_d, rsp1_err_d;
  logic [CMD_W-1:0]  mem_cmd_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic              mem_trig_d;

  logic              grant_valid_c, grant_idx_c;
  logic              ack_timeout_c, eval_fail_c;
  logic [ERR_W-1:0]  eval_err_c;
  chk_e              cur_chk_c;

  assign mem_val  = '0;
  assign mem_quad = QUAD;

  rr_arbiter2 u_arb (
    .CLK           (CLK),
    .reset         (reset),
    .en            ((state == ST_IDLE) && !mem_busy),
    .req           ({req1_valid, req0_valid}),
    .grant_valid_c (grant_valid_c),
    .grant_idx_c   (grant_idx_c)
  );

  // Step evaluation and ack timeout
  always_comb begin
    cur_chk_c     = step_chk(req_q.op, step_q);
    ack_timeout_c = ((ack_cnt_q + CNT_W'(1)) == CNT_W'(ACK_TIMEOUT));
    eval_err_c    = ERR_OK;
    if (cur_chk_c == CHK_WEL && !cap_q[SR1_WEL])     eval_err_c = ERR_WEL;
    else if (cur_chk_c == CHK_WIP && cap_q[SR1_WIP]) eval_err_c = ERR_TIMEOUT;
    eval_fail_c   = (eval_err_c != ERR_OK);
  end

  always_ff @(posedge CLK) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:      if (grant_valid_c) state_d = ST_DECODE;
      ST_DECODE:    state_d = op_legal(req_q.op) ? ST_ISSUE : ST_RESP;
      ST_ISSUE:     state_d = ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        if (mem_busy)           state_d = ST_WAIT_DONE;
        else if (ack_timeout_c) state_d = ST_RESP;
      end
      ST_WAIT_DONE: if (!mem_busy) state_d = ST_EVAL;
      ST_EVAL: begin
        if (eval_fail_c || step_last(req_q.op, step_q)) state_d = ST_RESP;
        else                                             state_d = ST_ISSUE;
      end
      ST_RESP:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_d        = req_q;
    gnt_d        = gnt_q;
    step_d       = step_q;
    ack_cnt_d    = ack_cnt_q;
    err_d        = err_q;
    cap_d        = cap_q;
    req0_ready_d = 1'b0;
    req1_ready_d = 1'b0;
    rsp0_valid_d = 1'b0;
    rsp1_valid_d = 1'b0;
    rsp0_data_d  = rsp0_data;
    rsp1_data_d  = rsp1_data;
    rsp0_err_d   = rsp0_err;
    rsp1_err_d   = rsp1_err;
    mem_cmd_d    = mem_cmd;
    mem_addr_d   = mem_addr;
    mem_trig_d   = mem_trig;
    case (state)
      ST_IDLE: begin
        if (grant_valid_c) begin
          req_d.op     = grant_idx_c ? req1_op : req0_op;
          req_d.addr   = grant_idx_c ? req1_addr : req0_addr;
          gnt_d        = grant_idx_c;
          req0_ready_d = !grant_idx_c;
          req1_ready_d = grant_idx_c;
          step_d       = '0;
          err_d        = ERR_OK;
          cap_d        = '0;
        end
      end
      ST_DECODE: if (!op_legal(req_q.op)) err_d = ERR_BADOP;
      ST_ISSUE: begin
        mem_cmd_d  = step_cmd(req_q.op, step_q);
        mem_addr_d = (req_q.op == OP_SE) ? req_q.addr : '0;
        mem_trig_d = 1'b1;
        ack_cnt_d  = '0;
      end
      ST_WAIT_ACK: begin
        if (mem_busy) begin
          mem_trig_d = 1'b0;
        end else if (ack_timeout_c) begin
          mem_trig_d = 1'b0;
          err_d      = ERR_TIMEOUT;
        end else begin
          ack_cnt_d  = ack_cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT_DONE: if (!mem_busy) cap_d = mem_data;
      ST_EVAL: begin
        if (eval_fail_c) err_d  = eval_err_c;
        else             step_d = step_q + STEP_W'(1);
      end
      ST_RESP: begin
        if (gnt_q) begin
          rsp1_valid_d = 1'b1;
          rsp1_data_d  = cap_q;
          rsp1_err_d   = err_q;
        end else begin
          rsp0_valid_d = 1'b1;
          rsp0_data_d  = cap_q;
          rsp0_err_d   = err_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      req_q      <= '0;
      gnt_q      <= 1'b0;
      step_q     <= '0;
      ack_cnt_q  <= '0;
      err_q      <= ERR_OK;
      cap_q      <= '0;
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_data  <= '0;
      rsp1_data  <= '0;
      rsp0_err   <= '0;
      rsp1_err   <= '0;
      mem_cmd    <= '0;
      mem_addr   <= '0;
      mem_trig   <= 1'b0;
    end else begin
      req_q      <= req_d;
      gnt_q      <= gnt_d;
      step_q     <= step_d;
      ack_cnt_q  <= ack_cnt_d;
      err_q      <= err_d;
      cap_q      <= cap_d;
      req0_ready <= req0_ready_d;
      req1_ready <= req1_ready_d;
      rsp0_valid <= rsp0_valid_d;
      rsp1_valid <= rsp1_valid_d;
      rsp0_data  <= rsp0_data_d;
      rsp1_data  <= rsp1_data_d;
      rsp0_err   <= rsp0_err_d;
      rsp1_err   <= rsp1_err_d;
      mem_cmd    <= mem_cmd_d;
      mem_addr   <= mem_addr_d;
      mem_trig   <= mem_trig_d;
    end
  end

endmodule

// File: tb/tb_flash_op_sequencer.sv
// Directed bench for flash_op_sequencer with a behavioural memory_controller
// model driving mem_busy/mem_data from the trigger handshake.
module tb_flash_op_sequencer;
  import flash_pkg::*;

  localparam logic [47:0] RDID_VAL = 48'h0120184D0100;
  localparam logic [47:0] RES_VAL  = 48'h000000000014;

  logic        CLK, reset;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [2:0]  req0_op, req1_op;
  logic [23:0] req0_addr, req1_addr;
  logic        rsp0_valid, rsp1_valid;
  logic [47:0] rsp0_data, rsp1_data;
  logic [1:0]  rsp0_err, rsp1_err;
  logic [7:0]  mem_cmd;
  logic [23:0] mem_addr, mem_val;
  logic        mem_trig, mem_quad, mem_busy;
  logic [47:0] mem_data;

  flash_op_sequencer #(.ACK_TIMEOUT(16), .QUAD(1'b0)) dut (
    .CLK(CLK), .reset(reset),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_addr(req0_addr), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_addr(req1_addr), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
    .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_val(mem_val), .mem_trig(mem_trig),
    .mem_quad(mem_quad), .mem_busy(mem_busy), .mem_data(mem_data)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory controller model
  bit          no_ack = 1'b0;
  int          busy_len = 2;
  logic [7:0]  sr1_seq [4];
  int          sr1_idx = 0;
  int          trig_hi = 0;
  int          overlap = 0;
  int          ready_busy = 0;
  logic [7:0]  cmd_log [$];
  logic [23:0] addr_log [$];

  initial begin
    int          phase;
    int          bcnt;
    logic [47:0] pend;
    phase = 0; bcnt = 0; pend = '0;
    mem_busy = 1'b0;
    mem_data = '0;
    forever begin
      @(negedge CLK);
      if (mem_trig) trig_hi++;
      if (mem_trig && mem_busy) overlap++;
      if ((req0_ready || req1_ready) && mem_busy) ready_busy++;
      if (phase == 0) begin
        if (mem_trig && !no_ack) begin
          cmd_log.push_back(mem_cmd);
          addr_log.push_back(mem_addr);
          case (mem_cmd)
            8'h9F: pend = RDID_VAL;
            8'hAB: pend = RES_VAL;
            8'h05: begin
              pend = {40'h0, sr1_seq[sr1_idx]};
              if (sr1_idx < 3) sr1_idx++;
            end
            default: pend = '0;
          endcase
          mem_busy = 1'b1;
          bcnt     = busy_len;
          phase    = 1;
        end
      end else if (bcnt == 0) begin
        mem_busy = 1'b0;
        mem_data = pend;
        phase    = 0;
      end else begin
        bcnt--;
      end
    end
  end

  // Handshake monitor
  int          rdy_cnt [2];
  int          rsp_cnt [2];
  logic [47:0] last_data [2];
  logic [1:0]  last_err [2];
  int          rsp_order [$];

  initial begin
    for (int i = 0; i < 2; i++) begin
      rdy_cnt[i] = 0; rsp_cnt[i] = 0; last_data[i] = '0; last_err[i] = '0;
    end
    forever begin
      @(negedge CLK);
      if (req0_ready) rdy_cnt[0]++;
      if (req1_ready) rdy_cnt[1]++;
      if (rsp0_valid) begin
        rsp_cnt[0]++; last_data[0] = rsp0_data; last_err[0] = rsp0_err; rsp_order.push_back(0);
      end
      if (rsp1_valid) begin
        rsp_cnt[1]++; last_data[1] = rsp1_data; last_err[1] = rsp1_err; rsp_order.push_back(1);
      end
    end
  end

  task automatic issue(input int r, input logic [2:0] op, input logic [23:0] addr);
    @(negedge CLK);
    if (r == 0) begin req0_valid = 1'b1; req0_op = op; req0_addr = addr; end
    else        begin req1_valid = 1'b1; req1_op = op; req1_addr = addr; end
  endtask

  task automatic wait_ready_drop(input int r);
    int b;
    int n;
    b = rdy_cnt[r];
    n = 0;
    while (rdy_cnt[r] == b && n < 200) begin @(posedge CLK); n++; end
    chk($sformatf("ready%0d_seen", r), 64'(rdy_cnt[r] - b), 64'd1);
    @(negedge CLK);
    if (r == 0) req0_valid = 1'b0;
    else        req1_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int r, input int b);
    int n;
    n = 0;
    while (rsp_cnt[r] == b && n < 500) begin @(posedge CLK); n++; end
    chk($sformatf("rsp%0d_seen", r), 64'(rsp_cnt[r] - b), 64'd1);
  endtask

  typedef struct {
    int          r;
    logic [2:0]  op;
    logic [23:0] addr;
    logic [15:0] sr1;
    logic [1:0]  err;
    logic [47:0] data;
    int          ncmd;
    logic [31:0] cmds;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int b0, b1, rb;
    int n;
    logic [31:0] cw;
    logic [7:0]  ecmd;
    vec_t v;

    vecs[0] = '{0, OP_RDID, 24'h000000, 16'h0000, ERR_OK,      RDID_VAL,   1, 32'h9F000000};
    vecs[1] = '{1, OP_SE,   24'h040000, 16'h0200, ERR_OK,      48'h0,      4, 32'h0605D805};
    vecs[2] = '{0, OP_BE,   24'h000000, 16'h0000, ERR_WEL,     48'h0,      2, 32'h06050000};
    vecs[3] = '{0, OP_RSR1, 24'h000000, 16'h0300, ERR_OK,      48'h03,     1, 32'h05000000};
    vecs[4] = '{1, OP_RES,  24'h000000, 16'h0000, ERR_OK,      RES_VAL,    1, 32'hAB000000};
    vecs[5] = '{0, 3'd7,    24'h000000, 16'h0000, ERR_BADOP,   48'h0,      0, 32'h00000000};
    vecs[6] = '{1, 3'd5,    24'h000000, 16'h0000, ERR_BADOP,   48'h0,      0, 32'h00000000};
    vecs[7] = '{1, OP_SE,   24'h0ABCDE, 16'h0201, ERR_TIMEOUT, 48'h01,     4, 32'h0605D805};
    vecs[8] = '{1, OP_BE,   24'h000000, 16'h0200, ERR_OK,      48'h0,      4, 32'h0605C705};

    for (int i = 0; i < 4; i++) sr1_seq[i] = 8'h00;
    reset = 1'b1;
    req0_valid = 1'b0; req0_op = '0; req0_addr = '0;
    req1_valid = 1'b0; req1_op = '0; req1_addr = '0;
    repeat (3) @(negedge CLK);

    chk("reset_ctrl", 64'({req0_ready, req1_ready, rsp0_valid, rsp1_valid, mem_trig, mem_quad}), 64'd0);
    chk("reset_cmd_addr", 64'({mem_cmd, mem_addr, mem_val}), 64'd0);
    chk("reset_rsp", 64'({rsp0_err, rsp1_err} | rsp0_data | rsp1_data), 64'd0);

    // Both requesters valid out of reset: 0 then 1, then the next tie goes to 0
    rsp_order.delete();
    req0_valid = 1'b1; req0_op = OP_RSR1;
    req1_valid = 1'b1; req1_op = OP_RSR1;
    @(negedge CLK);
    reset = 1'b0;
    b0 = rsp_cnt[0]; b1 = rsp_cnt[1];
    fork
      wait_ready_drop(0);
      wait_ready_drop(1);
    join
    n = 0;
    while ((rsp_cnt[0] == b0 || rsp_cnt[1] == b1) && n < 800) begin @(posedge CLK); n++; end
    repeat (4) @(posedge CLK);
    chk("tie1_rsp_total", 64'(rsp_order.size()), 64'd2);
    chk("tie1_first", 64'(rsp_order[0]), 64'd0);
    chk("tie1_second", 64'(rsp_order[1]), 64'd1);

    rsp_order.delete();
    fork
      begin issue(0, OP_RSR1, 24'h0); wait_ready_drop(0); end
      begin issue(1, OP_RSR1, 24'h0); wait_ready_drop(1); end
    join
    n = 0;
    while (rsp_order.size() < 2 && n < 800) begin @(posedge CLK); n++; end
    repeat (4) @(posedge CLK);
    chk("tie2_rsp_total", 64'(rsp_order.size()), 64'd2);
    chk("tie2_first", 64'(rsp_order[0]), 64'd0);
    chk("tie2_second", 64'(rsp_order[1]), 64'd1);

    // Table-driven single-op vectors
    for (int k = 0; k < 9; k++) begin
      v = vecs[k];
      cmd_log.delete(); addr_log.delete();
      sr1_seq[0] = v.sr1[15:8]; sr1_seq[1] = v.sr1[7:0];
      sr1_seq[2] = 8'h00; sr1_seq[3] = 8'h00;
      sr1_idx = 0;
      trig_hi = 0;
      rb = rdy_cnt[v.r]; b0 = rsp_cnt[0]; b1 = rsp_cnt[1];
      issue(v.r, v.op, v.addr);
      wait_ready_drop(v.r);
      wait_rsp(v.r, (v.r == 0) ? b0 : b1);
      repeat (4) @(posedge CLK);
      chk($sformatf("v%0d_err", k), 64'(last_err[v.r]), 64'(v.err));
      chk($sformatf("v%0d_err_held", k), 64'((v.r == 0) ? rsp0_err : rsp1_err), 64'(v.err));
      chk($sformatf("v%0d_data", k), 64'(last_data[v.r]), 64'(v.data));
      chk($sformatf("v%0d_ncmd", k), 64'(cmd_log.size()), 64'(v.ncmd));
      chk($sformatf("v%0d_trig_cycles", k), 64'(trig_hi), 64'(v.ncmd));
      chk($sformatf("v%0d_ready_pulses", k), 64'(rdy_cnt[v.r] - rb), 64'd1);
      chk($sformatf("v%0d_rsp_pulses", k),
          64'({32'(rsp_cnt[1] - b1), 32'(rsp_cnt[0] - b0)}),
          (v.r == 0) ? 64'h0000000000000001 : 64'h0000000100000000);
      cw = v.cmds;
      for (int i = 0; i < v.ncmd; i++) begin
        ecmd = cw[31-8*i -: 8];
        chk($sformatf("v%0d_cmd%0d", k, i), 64'(cmd_log[i]), 64'(ecmd));
        chk($sformatf("v%0d_addr%0d", k, i), 64'(addr_log[i]),
            (v.op == OP_SE) ? 64'(v.addr) : 64'd0);
      end
    end

    // Controller never acknowledges: trigger held for the full timeout
    no_ack = 1'b1;
    cmd_log.delete();
    trig_hi = 0;
    b0 = rsp_cnt[0];
    issue(0, OP_RDID, 24'h0);
    wait_ready_drop(0);
    wait_rsp(0, b0);
    repeat (4) @(posedge CLK);
    chk("to_err", 64'(last_err[0]), 64'(ERR_TIMEOUT));
    chk("to_trig_cycles", 64'(trig_hi), 64'd16);
    chk("to_data", 64'(last_data[0]), 64'd0);
    chk("to_trig_low", 64'(mem_trig), 64'd0);
    no_ack = 1'b0;

    // Reset while an SE waits on a long busy phase
    busy_len = 20;
    sr1_seq[0] = 8'h02; sr1_seq[1] = 8'h00; sr1_idx = 0;
    issue(1, OP_SE, 24'h040000);
    wait_ready_drop(1);
    n = 0;
    while (!mem_busy && n < 100) begin @(posedge CLK); n++; end
    chk("rst_busy_seen", 64'(mem_busy), 64'd1);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    reset = 1'b1;
    b0 = rsp_cnt[0]; b1 = rsp_cnt[1];
    @(negedge CLK);
    chk("rst_ctrl", 64'({req0_ready, req1_ready, rsp0_valid, rsp1_valid, mem_trig, mem_quad}), 64'd0);
    chk("rst_cmd_addr", 64'({mem_cmd, mem_addr}), 64'd0);
    chk("rst_rsp", 64'({rsp0_err, rsp1_err} | rsp0_data | rsp1_data), 64'd0);
    reset = 1'b0;
    cmd_log.delete();
    busy_len = 2;
    chk("rst_still_busy", 64'(mem_busy), 64'd1);
    issue(0, OP_RDID, 24'h0);
    wait_ready_drop(0);
    wait_rsp(0, b0);
    repeat (4) @(posedge CLK);
    chk("rst_no_rsp1", 64'(rsp_cnt[1] - b1), 64'd0);
    chk("rst_rdid_data", 64'(last_data[0]), 64'(RDID_VAL));
    chk("rst_rdid_err", 64'(last_err[0]), 64'(ERR_OK));
    chk("rst_ncmd", 64'(cmd_log.size()), 64'd1);
    chk("rst_cmd", 64'(cmd_log[0]), 64'h9F);
    chk("grant_during_busy", 64'(ready_busy), 64'd0);
    chk("trig_during_busy", 64'(overlap), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/flash_op_sequencer.md
Name: flash_op_sequencer

Overview:
- Sits between two requesters and the flash memory_controller. Requester 0 is the host/UART command path; requester 1 is the data logger.
- Arbitrates round-robin and expands high-level ops into the memory_controller command sequence. Write-type ops run WREN → verify WEL → op → final RSR1 check.
- Drives the controller's MEMTRIG/busy handshake and returns one response per accepted request.

Parameters:
- ACK_TIMEOUT, 16: max cycles between asserting mem_trig and seeing mem_busy high.
- QUAD, 0: constant value driven on mem_quad.

Ports:
- CLK  in  1  clock
- reset  in  1  synchronous, active-high
- req0_valid  in  1  request 0 present
- req0_op  in  3  0=RDID 1=RSR1 2=RES 3=SE 4=BE, others illegal
- req0_addr  in  24  sector address (SE only)
- req0_ready  out  1  one-cycle pulse: request 0 accepted
- rsp0_valid  out  1  one-cycle pulse: response 0
- rsp0_data  out  48  mem_data of the last read command of the op
- rsp0_err  out  2  0=OK 1=bad op 2=WEL not set 3=timeout/WIP stuck
- req1_valid, req1_op, req1_addr, req1_ready, rsp1_valid, rsp1_data, rsp1_err: same as requester 0
- mem_cmd  out  8  to MEMCMD
- mem_addr  out  24  to MEMADDR
- mem_val  out  24  to MEMVAL, tied 0
- mem_trig  out  1  to MEMTRIG
- mem_quad  out  1  to MEMQUAD, equals QUAD
- mem_busy  in  1  from MEM_CTRL_busy
- mem_data  in  48  from MEMDATA; SR1 is mem_data[7:0]

Behaviour:
- Reset values: all outputs 0; state IDLE; last_grant=1 (requester 0 wins first tie); step=0.
- IDLE:
  - If mem_busy=1, stay in IDLE.
  - Else, if exactly one reqN_valid, grant it.
  - If both are valid, grant the requester that is not last_grant.
  - On grant: latch op/addr, pulse reqN_ready for 1 cycle, update last_grant, go to DECODE.
- DECODE: build the step list.
  - RDID: [9F]
  - RSR1: [05]
  - RES: [AB]
  - SE: [06, 05chk-WEL, D8, 05chk-WIP]
  - BE: [06, 05chk-WEL, C7, 05chk-WIP]
  - Illegal op: go to RESP with err=1, no mem traffic.
- ISSUE: drive mem_cmd = step command and mem_addr = latched addr (0 for non-SE); set mem_trig=1, clear the ack counter, go to WAIT_ACK.
- WAIT_ACK:
  - Hold mem_trig=1 and mem_cmd/mem_addr stable.
  - When mem_busy=1: mem_trig←0, go to WAIT_DONE.
  - When the counter reaches ACK_TIMEOUT: mem_trig←0, err=3, go to RESP.
- WAIT_DONE: when mem_busy=0, capture mem_data and go to EVAL. There is no timeout here; the controller enforces its own erase/poll timeout.
- EVAL:
  - chk-WEL step with captured[1]=0: err=2, go to RESP. No erase is issued.
  - chk-WIP step with captured[0]=1: err=3, go to RESP.
  - Otherwise step++. Go to ISSUE if steps remain, else go to RESP with err=0.
- RESP:
  - Pulse rspN_valid for 1 cycle on the granted requester only.
  - rspN_data = last captured mem_data; rspN_err is held until the next response.
  - Then go to IDLE.
- Latency:
  - RDID response comes 5 cycles after grant plus the controller's busy time.
  - Minimum one full idle cycle between consecutive grants.
- A request arriving while the block is busy waits. reqN_valid must stay high until reqN_ready; the requester must not change op/addr while waiting.
- Reset mid-operation:
  - Outputs return to reset values immediately and no response is issued.
  - The controller may still complete; IDLE's mem_busy check prevents overlap.
- Simultaneous grant and new request from the same requester: the new request is only considered in the next IDLE.

Decomposition:
- Shared package flash_pkg:
  - op codes OP_RDID..OP_BE
  - command bytes CMD_RDID=9F, RSR1=05, RES=AB, WREN=06, SE=D8, BE=C7
  - error codes ERR_OK..ERR_TIMEOUT
  - SR1 bit indices WIP=0, WEL=1
- One sub-module rr_arbiter2: 2-way round-robin grant with last_grant register, used by IDLE.

Test Plan:
- req0 RDID, mem model returns 48'h0120184D0100 → mem_cmd=9F, one trig, rsp0_data=48'h0120184D0100, err=0.
- req1 SE addr 24'h040000, model SR1: 02 after WREN, 00 at end → cmd sequence 06,05,D8(addr 040000),05; rsp1_err=0.
- req0 BE, model SR1=00 after WREN → no C7 issued, rsp0_err=2.
- req0 and req1 both valid from reset, both RSR1 → req0 served first, then req1; next tie goes to req0. Exactly one rsp pulse each.
- Model never raises busy → mem_trig drops after 16 cycles, err=3. req0_op=7 → rsp0_err=1 with no mem_trig.
- Assert reset during WAIT_DONE of SE → all outputs 0 next cycle, no rsp. Next grant waits for mem_busy=0.
